// File: rtl/comp_arbiter.sv
// Two-requester compare arbiter: grants one SLT/SLTU-style compare at a time,
// alternating priority under contention, and holds the registered result until consumed.
module comp_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic            req0_u,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic            req1_u,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_eq,
    output logic            resp_lt,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            prio;
    logic            grant_id;
    logic            accept;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic            u_q;
    logic            id_q;
    logic            less_u;
    logic            less_s;
    logic            less;
    logic            equal;

    // A lone requester always wins; prio only breaks ties.
    assign grant_id = (req0_valid && req1_valid) ? prio : req1_valid;

    // Gated by rst_n so no ready is advertised while the block is held in reset.
    assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign resp_valid = (state == HOLD);
    assign busy       = (state != IDLE);

    always_comb begin
        // NOTE: default assigned first so every path drives state_nx; no latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CMP;
            CMP:     state_nx = HOLD;
            HOLD:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Signed less: differing sign bits decide alone, otherwise the low bits compare as unsigned.
    assign less_u = (op1_q < op2_q);
    assign less_s = (op1_q[XLEN-1] != op2_q[XLEN-1]) ? op1_q[XLEN-1]
                                                     : (op1_q[XLEN-2:0] < op2_q[XLEN-2:0]);
    assign less   = u_q ? less_u : less_s;
    assign equal  = (op1_q == op2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio        <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            u_q         <= 1'b0;
            id_q        <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_eq     <= 1'b0;
            resp_lt     <= 1'b0;
        end else begin
            if (accept) begin
                op1_q <= grant_id ? req1_op1 : req0_op1;
                op2_q <= grant_id ? req1_op2 : req0_op2;
                u_q   <= grant_id ? req1_u : req0_u;
                id_q  <= grant_id;
                prio  <= ~grant_id;
            end
            if (state == CMP) begin
                resp_lt     <= less;
                resp_eq     <= equal;
                resp_result <= {{(XLEN-1){1'b0}}, less};
                resp_id     <= id_q;
            end
        end
    end

endmodule
